// File: rtl/hazard_pkg.sv
// Shared constants for the forwarding/hazard controller: bypass select codes
// and the load-use stall FSM state encoding.
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int LAT_CNT_W = 4;

   typedef enum logic {
      HZ_IDLE  = 1'b0,
      HZ_STALL = 1'b1
   } hz_state_t;

endpackage

// File: rtl/fwd_src_match.sv
// Bypass select for a single ID/EX source operand: EX/MEM beats MEM/WB, and
// register 0 never forwards.
module fwd_src_match
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] i_src,
   input  logic [REG_ADDR_W-1:0] i_mem_rd,
   input  logic                  i_mem_reg_write,
   input  logic                  i_mem_mem_read,
   input  logic [REG_ADDR_W-1:0] i_wb_rd,
   input  logic                  i_wb_reg_write,
   input  logic                  i_suppress,
   output logic [1:0]            o_sel
);

   logic w_mem_hit;
   logic w_wb_hit;

   // A load in EX/MEM has no data yet; the load-use stall covers that case.
   assign w_mem_hit = i_mem_reg_write & ~i_mem_mem_read &
                      (i_mem_rd != '0) & (i_mem_rd == i_src);
   assign w_wb_hit  = i_wb_reg_write & (i_wb_rd != '0) & (i_wb_rd == i_src);

   always_comb begin
      o_sel = FWD_RF;
      if (i_suppress) begin
         o_sel = FWD_RF;
      end else if (w_mem_hit) begin
         o_sel = FWD_MEM;
      end else if (w_wb_hit) begin
         o_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Optional store-data forwarding from a MEM/WB load is enabled by STORE_FWD_EN.
module hazard_fwd_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [REG_ADDR_W-1:0]         id_rs,
   input  logic [REG_ADDR_W-1:0]         id_rt,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src,
   input  logic [REG_ADDR_W-1:0]         ex_rd,
   input  logic                          ex_reg_write,
   input  logic                          ex_mem_read,
   input  logic                          ex_mem_write,
   input  logic                          ex_jmp,
   input  logic [REG_ADDR_W-1:0]         mem_rd,
   input  logic                          mem_reg_write,
   input  logic                          mem_mem_read,
   input  logic [REG_ADDR_W-1:0]         wb_rd,
   input  logic                          wb_reg_write,
   input  logic                          wb_mem_read,
   input  logic                          flush,
   output logic [2*NUM_SRC-1:0]          fwd_sel,
   output logic                          fwd_store,
   output logic                          stall_if,
   output logic                          bubble_ex,
   output logic [CNT_W-1:0]              stall_cycles,
   output logic                          dbg_state
);

   localparam logic [LAT_CNT_W-1:0] LAT_M1  = LAT_CNT_W'(LOAD_LAT - 1);
   localparam logic [LAT_CNT_W-1:0] CNT_ONE = LAT_CNT_W'(1);
   localparam logic [CNT_W-1:0]     SAT_ONE = CNT_W'(1);

   hz_state_t              r_state;
   logic [LAT_CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]       r_stall_cycles;
   logic                   w_hz;
   logic                   w_stall;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         // Jump/link reuses src1 for the return address, so it must not bypass.
         localparam logic IS_SRC1 = (gi == 1);
         fwd_src_match #(
            .REG_ADDR_W (REG_ADDR_W)
         ) u_match (
            .i_src           (ex_src[gi*REG_ADDR_W +: REG_ADDR_W]),
            .i_mem_rd        (mem_rd),
            .i_mem_reg_write (mem_reg_write),
            .i_mem_mem_read  (mem_mem_read),
            .i_wb_rd         (wb_rd),
            .i_wb_reg_write  (wb_reg_write),
            .i_suppress      (ex_jmp & IS_SRC1),
            .o_sel           (fwd_sel[gi*2 +: 2])
         );
      end
   endgenerate

   assign w_hz = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                 ((ex_rd == id_rs) | (ex_rd == id_rt));

   // Stall is visible in the hazard cycle itself; flush and reset mask it.
   assign w_stall   = reset & ~flush & ((r_state == HZ_STALL) | w_hz);
   assign stall_if  = w_stall;
   assign bubble_ex = w_stall;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= HZ_IDLE;
         r_cnt          <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + SAT_ONE;
         end
         if (flush) begin
            r_state <= HZ_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               HZ_IDLE: begin
                  if (w_hz && (LOAD_LAT > 1)) begin
                     r_state <= HZ_STALL;
                     r_cnt   <= LAT_M1;
                  end
               end
               HZ_STALL: begin
                  r_cnt <= r_cnt - CNT_ONE;
                  if (r_cnt == CNT_ONE) begin
                     r_state <= HZ_IDLE;
                  end
               end
               default: begin
                  r_state <= HZ_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign dbg_state    = r_state;

`ifdef STORE_FWD_EN
   assign fwd_store = ex_mem_write & wb_mem_read & wb_reg_write & (wb_rd != '0) &
                      (wb_rd == ex_src[REG_ADDR_W +: REG_ADDR_W]);
`else
   logic w_unused;
   assign fwd_store = 1'b0;
   assign w_unused  = ^{ex_mem_write, wb_mem_read};
`endif

endmodule
